// File: rtl/gcd_pkg.sv
// Shared definitions for the Euclid GCD engine: FSM encoding and sizing helper.
package gcd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCheck,
    StMod,
    StDone
  } gcd_state_e;

  // Bits needed to hold the values 0..max_iter inclusive.
  function automatic int unsigned iter_width(input int unsigned max_iter);
    return $clog2(max_iter + 1);
  endfunction

endpackage

// File: rtl/modulo_seq.sv
// Restoring bit-serial remainder unit: rem_o = dividend_i mod divisor_i after exactly WIDTH cycles.
module modulo_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             done_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_bits;
  logic [WIDTH-1:0] r_div;
  logic [CntW-1:0]  r_cnt;
  logic             r_busy;
  logic             r_done;

  // One shift-subtract step; rem < div keeps the WIDTH+1 bit partial result in range.
  function automatic logic [WIDTH-1:0] rem_step(input logic [WIDTH-1:0] rem,
                                                input logic             bit_in,
                                                input logic [WIDTH-1:0] div);
    logic [WIDTH:0] t;
    t = {rem, bit_in};
    if (t >= {1'b0, div}) begin
      t = t - {1'b0, div};
    end
    return t[WIDTH-1:0];
  endfunction

  // The first step is folded into the start cycle so done lands exactly WIDTH cycles later.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_rem  <= '0;
      r_bits <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (flush_i) begin
        r_rem  <= '0;
        r_bits <= '0;
        r_cnt  <= '0;
        r_busy <= 1'b0;
      end else if (start_i) begin
        r_rem  <= rem_step('0, dividend_i[WIDTH-1], divisor_i);
        r_bits <= dividend_i << 1;
        r_div  <= divisor_i;
        r_cnt  <= CntW'(WIDTH - 1);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem  <= rem_step(r_rem, r_bits[WIDTH-1], r_div);
        r_bits <= r_bits << 1;
        r_cnt  <= r_cnt - CntW'(1);
        if (r_cnt == CntW'(1)) begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
      end
    end
  end

  assign rem_o  = r_rem;
  assign done_o = r_done;

endmodule

// File: rtl/gcd_engine.sv
// Self-sequenced Euclid GCD engine with start/ready/valid handshake, abort and iteration limit.
module gcd_engine
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned MAX_ITER = 32,
  parameter int unsigned ITER_W   = iter_width(MAX_ITER)
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [WIDTH-1:0]  Zahl1_i,
  input  logic [WIDTH-1:0]  Zahl2_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [WIDTH-1:0]  ergebnis_o,
  output logic [ITER_W-1:0] iter_o,
  output logic              err_o
);

  localparam logic [ITER_W-1:0] MaxIter = ITER_W'(MAX_ITER);

  gcd_state_e r_state, w_state_next;

  logic [WIDTH-1:0]  r_a, r_b;
  logic [ITER_W-1:0] r_iter;
  logic              r_ready, r_valid, r_err;
  logic [WIDTH-1:0]  r_ergebnis;
  logic [ITER_W-1:0] r_iter_out;

  logic             w_accept;
  logic             w_mod_start, w_flush, w_step, w_load_out, w_abort;
  logic [WIDTH-1:0] w_mod_rem;
  logic             w_mod_done;

  assign w_accept = start_i & r_ready;

  modulo_seq #(
    .WIDTH(WIDTH)
  ) u_modulo_seq (
    .clk        (clk),
    .rst_i      (rst_i),
    .start_i    (w_mod_start),
    .flush_i    (w_flush),
    .dividend_i (r_a),
    .divisor_i  (r_b),
    .rem_o      (w_mod_rem),
    .done_o     (w_mod_done)
  );

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // DONE is entered with outputs not yet loaded; its first cycle publishes the result.
  always_comb begin
    w_state_next = r_state;
    w_mod_start  = 1'b0;
    w_flush      = 1'b0;
    w_step       = 1'b0;
    w_load_out   = 1'b0;
    w_abort      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) w_state_next = StCheck;
      end
      StCheck: begin
        if (abort_i) begin
          w_flush      = 1'b1;
          w_abort      = 1'b1;
          w_state_next = StDone;
        end else if (r_b == '0 || r_iter == MaxIter) begin
          w_state_next = StDone;
        end else begin
          w_mod_start  = 1'b1;
          w_state_next = StMod;
        end
      end
      StMod: begin
        if (abort_i) begin
          w_flush      = 1'b1;
          w_abort      = 1'b1;
          w_state_next = StDone;
        end else if (w_mod_done) begin
          w_step       = 1'b1;
          w_state_next = StCheck;
        end
      end
      StDone: begin
        if (w_accept) begin
          w_state_next = StCheck;
        end else if (!r_valid) begin
          w_load_out = 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_a        <= '0;
      r_b        <= '0;
      r_iter     <= '0;
      r_ready    <= 1'b1;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_ergebnis <= '0;
      r_iter_out <= '0;
    end else begin
      if (w_accept) begin
        r_a        <= Zahl1_i;
        r_b        <= Zahl2_i;
        r_iter     <= '0;
        r_ready    <= 1'b0;
        r_valid    <= 1'b0;
        r_err      <= 1'b0;
        r_iter_out <= '0;
      end
      if (w_step) begin
        r_a    <= r_b;
        r_b    <= w_mod_rem;
        r_iter <= r_iter + ITER_W'(1);
      end
      // b != 0 here means the iteration limit stopped us; b == 0 errs only for gcd(0,0).
      if (w_load_out) begin
        r_ready    <= 1'b1;
        r_valid    <= 1'b1;
        r_ergebnis <= r_a;
        r_iter_out <= r_iter;
        r_err      <= (r_b != '0) || (r_a == '0);
      end
      if (w_abort) begin
        r_ready    <= 1'b1;
        r_valid    <= 1'b1;
        r_ergebnis <= '0;
        r_iter_out <= r_iter;
        r_err      <= 1'b1;
      end
    end
  end

  assign ready_o    = r_ready;
  assign valid_o    = r_valid;
  assign ergebnis_o = r_ergebnis;
  assign iter_o     = r_iter_out;
  assign err_o      = r_err;

endmodule

// File: tb/tb_gcd_engine.sv
// Directed self-checking bench for gcd_engine (default limit plus a MAX_ITER=8 instance).
module tb_gcd_engine;

  localparam int unsigned WIDTH = 16;

  logic              clk;
  logic              rst_i;
  logic              start_i;
  logic              abort_i;
  logic [WIDTH-1:0]  zahl1;
  logic [WIDTH-1:0]  zahl2;
  logic              ready_o, valid_o, err_o;
  logic [WIDTH-1:0]  ergebnis_o;
  logic [5:0]        iter_o;
  logic              lim_ready, lim_valid, lim_err;
  logic [WIDTH-1:0]  lim_ergebnis;
  logic [5:0]        lim_iter;

  int n_checks = 0;
  int n_errors = 0;
  int cycles;

  gcd_engine #(
    .WIDTH    (WIDTH),
    .MAX_ITER (32),
    .ITER_W   (6)
  ) dut (
    .clk        (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .Zahl1_i    (zahl1),
    .Zahl2_i    (zahl2),
    .ready_o    (ready_o),
    .valid_o    (valid_o),
    .ergebnis_o (ergebnis_o),
    .iter_o     (iter_o),
    .err_o      (err_o)
  );

  gcd_engine #(
    .WIDTH    (WIDTH),
    .MAX_ITER (8),
    .ITER_W   (6)
  ) dut_lim (
    .clk        (clk),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .abort_i    (abort_i),
    .Zahl1_i    (zahl1),
    .Zahl2_i    (zahl2),
    .ready_o    (lim_ready),
    .valid_o    (lim_valid),
    .ergebnis_o (lim_ergebnis),
    .iter_o     (lim_iter),
    .err_o      (lim_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    zahl1   = a;
    zahl2   = b;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Counts edges until valid is seen; stops at 1000 so a stuck engine fails the latency check.
  task automatic wait_valid(input bit lim, output int n);
    n = 0;
    while (!(lim ? lim_valid : valid_o) && n < 1000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    rst_i   = 1'b1;
    start_i = 1'b0;
    abort_i = 1'b0;
    zahl1   = '0;
    zahl2   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_ergebnis", 32'(ergebnis_o), 32'd0);
    check("rst_iter", 32'(iter_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    tick();

    // 48,18: 48%18=12, 18%12=6, 12%6=0 -> 6 after 3 steps, 2+3*17 cycles
    do_start(16'd48, 16'd18);
    check("t1_ready_busy", 32'(ready_o), 32'd0);
    wait_valid(1'b0, cycles);
    check("t1_latency", 32'(cycles), 32'd53);
    check("t1_ergebnis", 32'(ergebnis_o), 32'd6);
    check("t1_iter", 32'(iter_o), 32'd3);
    check("t1_err", 32'(err_o), 32'd0);
    tick();

    // 18,48: swap step first -> 4 steps
    do_start(16'd18, 16'd48);
    wait_valid(1'b0, cycles);
    check("t2_latency", 32'(cycles), 32'd70);
    check("t2_ergebnis", 32'(ergebnis_o), 32'd6);
    check("t2_iter", 32'(iter_o), 32'd4);
    tick();

    do_start(16'd7, 16'd0);
    wait_valid(1'b0, cycles);
    check("t3a_latency", 32'(cycles), 32'd2);
    check("t3a_ergebnis", 32'(ergebnis_o), 32'd7);
    check("t3a_iter", 32'(iter_o), 32'd0);
    check("t3a_err", 32'(err_o), 32'd0);
    tick();

    do_start(16'd0, 16'd5);
    wait_valid(1'b0, cycles);
    check("t3b_latency", 32'(cycles), 32'd19);
    check("t3b_ergebnis", 32'(ergebnis_o), 32'd5);
    check("t3b_iter", 32'(iter_o), 32'd1);
    check("t3b_err", 32'(err_o), 32'd0);
    tick();

    do_start(16'd0, 16'd0);
    wait_valid(1'b0, cycles);
    check("t3c_latency", 32'(cycles), 32'd2);
    check("t3c_ergebnis", 32'(ergebnis_o), 32'd0);
    check("t3c_err", 32'(err_o), 32'd1);
    tick();

    // Consecutive Fibonacci F24,F23: 22 steps to gcd 1; limit 8 stops at pair (F16,F15)
    do_start(16'd46368, 16'd28657);
    wait_valid(1'b1, cycles);
    check("t4_lim_latency", 32'(cycles), 32'd138);
    check("t4_lim_err", 32'(lim_err), 32'd1);
    check("t4_lim_iter", 32'(lim_iter), 32'd8);
    check("t4_lim_ergebnis", 32'(lim_ergebnis), 32'd987);
    check("t4_lim_ready", 32'(lim_ready), 32'd1);
    wait_valid(1'b0, cycles);
    check("t4_latency", 32'(cycles + 138), 32'd376);
    check("t4_ergebnis", 32'(ergebnis_o), 32'd1);
    check("t4_iter", 32'(iter_o), 32'd22);
    check("t4_err", 32'(err_o), 32'd0);
    tick();

    // Abort sampled at edge 20 after accept
    do_start(16'd48, 16'd18);
    repeat (19) tick();
    check("t5_busy_valid", 32'(valid_o), 32'd0);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("t5_abort_valid", 32'(valid_o), 32'd1);
    check("t5_abort_err", 32'(err_o), 32'd1);
    check("t5_abort_ergebnis", 32'(ergebnis_o), 32'd0);
    check("t5_abort_ready", 32'(ready_o), 32'd1);
    do_start(16'd12, 16'd8);
    wait_valid(1'b0, cycles);
    check("t5_restart_latency", 32'(cycles), 32'd36);
    check("t5_restart_ergebnis", 32'(ergebnis_o), 32'd4);
    check("t5_restart_err", 32'(err_o), 32'd0);
    tick();

    // Async reset between edges while in MOD
    do_start(16'd48, 16'd18);
    repeat (5) tick();
    #2;
    rst_i = 1'b1;
    #1;
    check("t6_rst_ergebnis", 32'(ergebnis_o), 32'd0);
    check("t6_rst_ready", 32'(ready_o), 32'd1);
    check("t6_rst_valid", 32'(valid_o), 32'd0);
    check("t6_rst_iter", 32'(iter_o), 32'd0);
    @(negedge clk);
    rst_i = 1'b0;
    tick();

    // Start while busy must be ignored
    do_start(16'd48, 16'd18);
    repeat (10) tick();
    check("t6_busy_ready", 32'(ready_o), 32'd0);
    do_start(16'd100, 16'd75);
    wait_valid(1'b0, cycles);
    check("t6_ignore_latency", 32'(cycles), 32'd42);
    check("t6_ignore_ergebnis", 32'(ergebnis_o), 32'd6);
    check("t6_ignore_iter", 32'(iter_o), 32'd3);

    // Back-to-back start straight from DONE
    do_start(16'd7, 16'd0);
    check("t6_b2b_valid_clr", 32'(valid_o), 32'd0);
    wait_valid(1'b0, cycles);
    check("t6_b2b_latency", 32'(cycles), 32'd2);
    check("t6_b2b_ergebnis", 32'(ergebnis_o), 32'd7);
    check("t6_b2b_iter", 32'(iter_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
